// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine between the multicycle control FSM and
// the data memory bus. A one-cycle start_i launches a single req/ack bus
// transaction with byte enables and store-lane steering. The unit returns
// sign/zero-extended load data, a one-cycle done pulse and error flags.
//
// Ports
//   clk_i, rst_ni       clock; synchronous active-low reset
//   start_i             one-cycle request pulse (honoured only when idle)
//   store_i, funct3_i   access type, sampled with start_i
//   addr_i, wdata_i     byte address and store data, sampled with start_i
//   busy_o              high from the cycle after an accepted start through done
//   done_o              one-cycle completion pulse
//   rdata_o             extended load result, held until overwritten by a load
//   err_align_o         misaligned address or illegal funct3 (valid with done)
//   err_timeout_o       no mem_ack_i within TIMEOUT cycles (valid with done)
//   mem_*_o / mem_*_i   memory bus request/ack handshake
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_align_o,
    output logic        err_timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lsb_q;
    logic              busy_q, done_q, err_align_q, err_timeout_q;
    logic              mem_req_q, mem_we_q;
    logic [31:0]       rdata_q, mem_addr_q, mem_wdata_q;
    logic [3:0]        mem_be_q;

    logic              legal_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       lane_d;
    logic [31:0]       rdata_d;

    // Legality/alignment check and bus-lane setup for the incoming request.
    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        case (funct3_i)
            3'b000, 3'b100: legal_d = 1'b1;
            3'b001, 3'b101: legal_d = ~addr_i[0];
            3'b010:         legal_d = (addr_i[1:0] == 2'b00);
            default:        legal_d = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata_i;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend.
    always_comb begin
        lane_d  = mem_rdata_i >> {lsb_q, 3'b000};
        rdata_d = lane_d;
        case (funct3_q)
            3'b000:  rdata_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b100:  rdata_d = {24'h000000, lane_d[7:0]};
            3'b001:  rdata_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b101:  rdata_d = {16'h0000, lane_d[15:0]};
            default: rdata_d = lane_d;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            funct3_q      <= 3'b000;
            lsb_q         <= 2'b00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            rdata_q       <= 32'h0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_be_q      <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        funct3_q      <= funct3_i;
                        lsb_q         <= addr_i[1:0];
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                        err_timeout_q <= 1'b0;
                        if (legal_d) begin
                            state_q     <= S_REQ;
                            err_align_q <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= store_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end else begin
                            // Rejected request skips the bus entirely.
                            state_q     <= S_FIN;
                            err_align_q <= 1'b1;
                            done_q      <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        state_q   <= S_FIN;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        if (!mem_we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q       <= S_FIN;
                        mem_req_q     <= 1'b0;
                        done_q        <= 1'b1;
                        err_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign err_align_o   = err_align_q;
    assign err_timeout_o = err_timeout_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_be_o      = mem_be_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, alignment errors,
// bus timeout, mid-transaction reset and start-while-busy behaviour.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, err_align, err_timeout;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int tests  = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .store_i      (store),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .busy_o       (busy),
        .done_o       (done),
        .rdata_o      (rdata),
        .err_align_o  (err_align),
        .err_timeout_o(err_timeout),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle (cycle 0); returns positioned in cycle 1.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        start  = 1'b1;
        store  = st;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        step();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
        tests++; if ({err_align, err_timeout, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {err_align, err_timeout, mem_we}); end
        tests++; if (mem_be !== 4'b0000) begin errors++; $display("FAIL reset_be got %b exp 0000", mem_be); end
        tests++; if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", rdata, mem_addr, mem_wdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        tests++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lw_req got %b exp 1", mem_req); end
        tests++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL lw_be got %b exp 1111", mem_be); end
        tests++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", mem_addr); end
        tests++; if ({busy, done, mem_we} !== 3'b100) begin errors++; $display("FAIL lw_c1_flags got %b exp 100", {busy, done, mem_we}); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        tests++; if (done !== 1'b1) begin errors++; $display("FAIL lw_done_c2 got %b exp 1", done); end
        tests++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rdata); end
        tests++; if ({mem_req, busy, err_align, err_timeout} !== 4'b0100) begin errors++; $display("FAIL lw_c2_flags got %b exp 0100", {mem_req, busy, err_align, err_timeout}); end
        step();
        tests++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL lw_c3_idle got %b exp 00", {done, busy}); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [3:0]  bes [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3s[i], ads[i], 32'h0);
            tests++; if (mem_be !== bes[i]) begin errors++; $display("FAIL ext%0d_be got %b exp %b", i, mem_be, bes[i]); end
            tests++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL ext%0d_addr got %h exp 00000100", i, mem_addr); end
            mem_ack = 1'b1; mem_rdata = 32'h8011_2233;
            step();
            mem_ack = 1'b0;
            tests++; if ({done, rdata} !== {1'b1, exp[i]}) begin errors++; $display("FAIL ext%0d_rdata got done=%b %h exp done=1 %h", i, done, rdata, exp[i]); end
            step();
        end
    endtask

    task automatic test_store();
        // rdata after the last load is 0x00002233 and must survive stores.
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
        for (int c = 1; c <= 3; c++) begin
            tests++; if ({mem_req, mem_we, done} !== 3'b110) begin errors++; $display("FAIL sh_c%0d_flags got %b exp 110", c, {mem_req, mem_we, done}); end
            tests++; if ({mem_be, mem_wdata, mem_addr} !== {4'b1100, 32'hABCD_ABCD, 32'h200}) begin errors++; $display("FAIL sh_c%0d_bus got %b %h %h exp 1100 abcdabcd 00000200", c, mem_be, mem_wdata, mem_addr); end
            step();
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        tests++; if ({done, mem_req, err_align, err_timeout} !== 4'b1000) begin errors++; $display("FAIL sh_done_c5 got %b exp 1000", {done, mem_req, err_align, err_timeout}); end
        tests++; if (rdata !== 32'h0000_2233) begin errors++; $display("FAIL sh_rdata_kept got %h exp 00002233", rdata); end
        step();
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_565A);
        tests++; if ({mem_be, mem_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++; $display("FAIL sb_bus got %b %h exp 0010 5a5a5a5a", mem_be, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        tests++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_align();
        logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b001};
        logic [31:0] ads [3] = '{32'h101, 32'h100, 32'h103};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, f3s[i], ads[i], 32'h0);
            tests++; if ({done, err_align, mem_req, busy} !== 4'b1101) begin errors++; $display("FAIL align%0d_c1 got %b exp 1101", i, {done, err_align, mem_req, busy}); end
            step();
            tests++; if ({done, busy, mem_req, err_align} !== 4'b0001) begin errors++; $display("FAIL align%0d_c2 got %b exp 0001", i, {done, busy, mem_req, err_align}); end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        mem_rdata = 32'h0BAD_0BAD;
        tests++; if (err_align !== 1'b0) begin errors++; $display("FAIL to_err_align_cleared got %b exp 0", err_align); end
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        tests++; if (n != 16) begin errors++; $display("FAIL to_req_cycles got %0d exp 16", n); end
        tests++; if ({done, err_timeout, err_align} !== 3'b110) begin errors++; $display("FAIL to_done got %b exp 110", {done, err_timeout, err_align}); end
        tests++; if (rdata !== 32'h0000_2233) begin errors++; $display("FAIL to_rdata_kept got %h exp 00002233", rdata); end
        step();
        tests++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL to_idle got %b exp 00", {done, busy}); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tests++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", mem_req); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL rmid_dropped got %b exp 00", {mem_req, busy}); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        tests++; if ({done, busy, mem_req} !== 3'b000) begin errors++; $display("FAIL rmid_late_ack got %b exp 000", {done, busy, mem_req}); end
        tests++; if (rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h exp 00000000", rdata); end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        // Second start while busy must be dropped.
        start = 1'b1; store = 1'b1; funct3 = 3'b010; addr = 32'h600; wdata = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        tests++; if ({mem_addr, mem_we} !== {32'h500, 1'b0}) begin errors++; $display("FAIL b2b_addr got %h we=%b exp 00000500 we=0", mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        tests++; if ({done, rdata} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL b2b_done got done=%b %h exp done=1 cafef00d", done, rdata); end
        // Start during the done cycle is dropped as well.
        start = 1'b1;
        step();
        start = 1'b0;
        tests++; if ({done, busy, mem_req} !== 3'b000) begin errors++; $display("FAIL b2b_no_queue got %b exp 000", {done, busy, mem_req}); end
        // Ack while idle has no effect.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        tests++; if ({done, busy, rdata} !== {2'b00, 32'hCAFE_F00D}) begin errors++; $display("FAIL idle_ack got %b %h exp 00 cafef00d", {done, busy}, rdata); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_align();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
